// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and state encoding for the MCP3002 SPI master
package adc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CS_SETUP = 2'd1,
      ST_SHIFT    = 2'd2
   } adc_state_t;

   localparam int FRAME_BITS      = 16;
   localparam int DATA_FIRST_BIT  = 6;
   localparam int DATA_BITS       = 10;
   localparam int DEFAULT_CLK_DIV = 25;

   // Command prefix, frame bits 4..0: MSBF, ODD(slot), SGL, START, leading zero.
   // The ODD slot is filled with the latched channel at run time.
   localparam logic [4:0] CMD_FIXED   = 5'b10110;
   localparam int         CMD_ODD_BIT = 3;

   // Level to drive on adc_din while frame bit idx is on the wire.
   function automatic logic frame_bit(input logic [3:0] idx, input logic ch);
      logic [FRAME_BITS-1:0] w_frame;
      w_frame              = '0;
      w_frame[4:0]         = CMD_FIXED;
      w_frame[CMD_ODD_BIT] = ch;
      return w_frame[idx];
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCK prescaler producing half-period ticks and the SCK level
module spi_clk_div
   import adc_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick,
   output logic o_rise_tick,
   output logic o_fall_tick,
   output logic o_sck
);

   localparam logic [7:0] TC = 8'(CLK_DIV - 1);

   logic [7:0] r_cnt;
   logic       r_sck;
   logic       w_tc;

   assign w_tc = (r_cnt == TC);

   // Free-running half-period counter, held at zero while cleared
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (w_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // SCK only toggles when shifting; it idles low otherwise
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) begin
         r_sck <= 1'b0;
      end else if (w_tc && i_en) begin
         r_sck <= ~r_sck;
      end
   end

   // Ticks are qualified by the current SCK level so they mark the edge about to be made
   assign o_tick      = w_tc;
   assign o_rise_tick = w_tc & i_en & ~r_sck;
   assign o_fall_tick = w_tc & i_en &  r_sck;
   assign o_sck       = r_sck;

endmodule

// File: rtl/spi2adc.sv
// rtl/spi2adc.sv - SPI master running one 16-bit MCP3002 conversion per start pulse
module spi2adc
   import adc_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic                 sysclk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 channel,
   input  logic                 adc_dout,
   output logic                 adc_cs_n,
   output logic                 adc_sck,
   output logic                 adc_din,
   output logic [DATA_BITS-1:0] data_from_adc,
   output logic                 data_valid,
   output logic                 busy
);

   adc_state_t           r_state;
   adc_state_t           w_state_nxt;
   logic                 w_start_frame;
   logic                 w_end_frame;
   logic                 w_tick;
   logic                 w_rise_tick;
   logic                 w_fall_tick;
   logic                 w_sck;
   logic                 r_ch;
   logic [3:0]           r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_cs_n;
   logic                 r_din;
   logic                 r_valid;
   logic                 r_busy;

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .i_clk       (sysclk),
      .i_rst_n     (rst_n),
      .i_clr       (r_state == ST_IDLE),
      .i_en        (r_state == ST_SHIFT),
      .o_tick      (w_tick),
      .o_rise_tick (w_rise_tick),
      .o_fall_tick (w_fall_tick),
      .o_sck       (w_sck)
   );

   // State register
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: start is only looked at in IDLE, so a start while busy is dropped
   always_comb begin
      w_state_nxt   = r_state;
      w_start_frame = 1'b0;
      w_end_frame   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt   = ST_CS_SETUP;
               w_start_frame = 1'b1;
            end
         end
         ST_CS_SETUP: begin
            if (w_tick) begin
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_fall_tick && r_idx == 4'(FRAME_BITS - 1)) begin
               w_state_nxt = ST_IDLE;
               w_end_frame = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Frame datapath: command out on falling edges, sample in on rising edges
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_cs_n  <= 1'b1;
         r_din   <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ch    <= 1'b0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_valid <= 1'b0;
         if (w_start_frame) begin
            r_cs_n <= 1'b0;
            r_busy <= 1'b1;
            r_ch   <= channel;
            r_idx  <= '0;
         end
         if (r_state == ST_CS_SETUP && w_tick) begin
            r_din <= frame_bit(4'd0, r_ch);
         end
         // Bit 5 is the ADC null bit and is skipped; D9..D0 arrive MSB first
         if (w_rise_tick && r_idx >= 4'(DATA_FIRST_BIT)) begin
            r_shift <= {r_shift[DATA_BITS-2:0], adc_dout};
         end
         if (w_end_frame) begin
            r_cs_n  <= 1'b1;
            r_din   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (w_fall_tick) begin
            r_idx <= r_idx + 4'd1;
            r_din <= frame_bit(r_idx + 4'd1, r_ch);
         end
      end
   end

   assign adc_cs_n      = r_cs_n;
   assign adc_sck       = w_sck;
   assign adc_din       = r_din;
   assign data_from_adc = r_data;
   assign data_valid    = r_valid;
   assign busy          = r_busy;

endmodule

// File: tb/tb_spi2adc.sv
// tb/tb_spi2adc.sv - scoreboard bench for spi2adc at CLK_DIV 25 and 2
module tb_spi2adc;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       channel_a = 1'b0, channel_b = 1'b0;
   logic       cs_a, sck_a, din_a, valid_a, busy_a;
   logic       cs_b, sck_b, din_b, valid_b, busy_b;
   logic [9:0] data_a, data_b;
   logic [1:0] dout_v = 2'b00;
   logic [1:0] cs_v, sck_v, din_v, valid_v;

   assign cs_v    = {cs_b, cs_a};
   assign sck_v   = {sck_b, sck_a};
   assign din_v   = {din_b, din_a};
   assign valid_v = {valid_b, valid_a};

   spi2adc #(.CLK_DIV(25)) dut_a (
      .sysclk(clk), .rst_n(rst_n), .start(start_a), .channel(channel_a),
      .adc_dout(dout_v[0]), .adc_cs_n(cs_a), .adc_sck(sck_a), .adc_din(din_a),
      .data_from_adc(data_a), .data_valid(valid_a), .busy(busy_a)
   );

   spi2adc #(.CLK_DIV(2)) dut_b (
      .sysclk(clk), .rst_n(rst_n), .start(start_b), .channel(channel_b),
      .adc_dout(dout_v[1]), .adc_cs_n(cs_b), .adc_sck(sck_b), .adc_din(din_b),
      .data_from_adc(data_b), .data_valid(valid_b), .busy(busy_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural MCP3002 models (index 0 = dut_a, 1 = dut_b)
   logic [9:0]  ch0_val = 10'h000, ch1_val = 10'h000;
   logic [9:0]  b_samp[3] = '{10'h001, 10'h200, 10'h155};
   logic [1:0]  prev_cs = 2'b11, prev_sck = 2'b00;
   int          rises[2]  = '{0, 0};
   int          frames[2] = '{0, 0};
   logic [15:0] cmd_m[2]  = '{16'h0, 16'h0};

   function automatic logic [9:0] model_sample(input int g);
      if (g == 0) return cmd_m[0][3] ? ch1_val : ch0_val;
      return b_samp[(frames[1] >= 1 && frames[1] <= 3) ? frames[1] - 1 : 0];
   endfunction

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (prev_cs[g] && !cs_v[g]) begin
            rises[g]  = 0;
            cmd_m[g]  = 16'h0;
            frames[g] = frames[g] + 1;
            dout_v[g] = 1'b0;
         end else if (!cs_v[g] && !prev_sck[g] && sck_v[g]) begin
            if (rises[g] < 16) cmd_m[g][rises[g]] = din_v[g];
            rises[g] = rises[g] + 1;
         end else if (!cs_v[g] && prev_sck[g] && !sck_v[g]) begin
            if (rises[g] >= 6 && rises[g] <= 15) dout_v[g] = model_sample(g)[15 - rises[g]];
            else dout_v[g] = 1'b0;
         end
         prev_cs[g]  = cs_v[g];
         prev_sck[g] = sck_v[g];
      end
   end

   // ---------------- scoreboard
   typedef struct {
      int         g;
      logic [9:0] data;
      logic [4:0] cmd;
      int         t0;
      int         lat;
   } item_t;

   item_t sb_q[$];
   item_t mon_it;
   logic [1:0] prev_v = 2'b00;

   task automatic push(input int g, input logic [9:0] d, input logic [4:0] c, input int t0, input int lat);
      item_t it;
      it.g = g; it.data = d; it.cmd = c; it.t0 = t0; it.lat = lat;
      sb_q.push_back(it);
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (valid_v[g]) begin
            chk($sformatf("valid_single dut%0d", g), 32'(prev_v[g]), 32'd0);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid dut%0d: data %0h, required no valid", g, (g == 1) ? data_b : data_a);
            end else begin
               mon_it = sb_q.pop_front();
               chk("dut_id", 32'(g), 32'(mon_it.g));
               chk($sformatf("data dut%0d", g), 32'((g == 1) ? data_b : data_a), 32'(mon_it.data));
               chk($sformatf("cmd_bits dut%0d", g), 32'(cmd_m[g][4:0]), 32'(mon_it.cmd));
               chk($sformatf("sck_rises dut%0d", g), 32'(rises[g]), 32'd16);
               chk($sformatf("latency dut%0d", g), 32'(cyc - mon_it.t0), 32'(mon_it.lat));
            end
         end
         prev_v[g] = valid_v[g];
      end
   end

   // ---------------- stimulus helpers (called at a negedge)
   task automatic start_conv(input int g, input logic ch);
      if (g == 0) begin channel_a = ch; start_a = 1'b1; end
      else        begin channel_b = ch; start_b = 1'b1; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d items pending after %0d cycles, required 0", sb_q.size(), budget);
      end
   endtask

   initial begin
      #5ms;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   int n;
   int t0b;

   initial begin
      // Reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst cs_n a", 32'(cs_a), 32'd1);   chk("rst cs_n b", 32'(cs_b), 32'd1);
      chk("rst sck a", 32'(sck_a), 32'd0);   chk("rst sck b", 32'(sck_b), 32'd0);
      chk("rst din a", 32'(din_a), 32'd0);   chk("rst din b", 32'(din_b), 32'd0);
      chk("rst data a", 32'(data_a), 32'd0); chk("rst data b", 32'(data_b), 32'd0);
      chk("rst valid a", 32'(valid_a), 32'd0); chk("rst valid b", 32'(valid_b), 32'd0);
      chk("rst busy a", 32'(busy_a), 32'd0); chk("rst busy b", 32'(busy_b), 32'd0);

      // Basic conversion on CH0
      ch0_val = 10'h2A5; ch1_val = 10'h000;
      push(0, 10'h2A5, 5'b10110, cyc + 1, 825);
      start_conv(0, 1'b0);
      chk("busy after start", 32'(busy_a), 32'd1);
      chk("cs_n after start", 32'(cs_a), 32'd0);
      drain(1000);
      repeat (50) @(negedge clk);
      chk("data hold", 32'(data_a), 32'h2A5);
      chk("idle busy", 32'(busy_a), 32'd0);
      chk("idle cs_n", 32'(cs_a), 32'd1);
      chk("idle sck", 32'(sck_a), 32'd0);

      // Channel select, with channel toggled mid-frame
      ch0_val = 10'h000; ch1_val = 10'h3FF;
      push(0, 10'h3FF, 5'b11110, cyc + 1, 825);
      start_conv(0, 1'b1);
      repeat (99) @(negedge clk);
      channel_a = 1'b0;
      drain(1000);

      // Start while busy is ignored; next start after valid is accepted
      ch0_val = 10'h123;
      push(0, 10'h123, 5'b10110, cyc + 1, 825);
      start_conv(0, 1'b0);
      repeat (99) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chk("busy during ignored start", 32'(busy_a), 32'd1);
      drain(1000);
      @(negedge clk);
      ch0_val = 10'h0F0;
      push(0, 10'h0F0, 5'b10110, cyc + 1, 825);
      start_conv(0, 1'b0);
      drain(1000);

      // Reset mid-frame at the 8th SCK rising edge
      @(negedge clk);
      ch0_val = 10'h3C3;
      start_conv(0, 1'b0);
      @(negedge clk);
      n = 0;
      while (rises[0] < 8 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reached sck edge 8", 32'(rises[0] >= 8), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst cs_n", 32'(cs_a), 32'd1);
      chk("midrst busy", 32'(busy_a), 32'd0);
      chk("midrst sck", 32'(sck_a), 32'd0);
      chk("midrst data", 32'(data_a), 32'd0);
      rst_n = 1'b1;
      repeat (900) @(negedge clk);
      chk("post-abort data", 32'(data_a), 32'd0);
      ch0_val = 10'h1C7;
      push(0, 10'h1C7, 5'b10110, cyc + 1, 825);
      start_conv(0, 1'b0);
      drain(1000);

      // Continuous sampling at CLK_DIV=2 with start held high
      t0b = cyc + 1;
      push(1, 10'h001, 5'b10110, t0b,       66);
      push(1, 10'h200, 5'b10110, t0b + 67,  66);
      push(1, 10'h155, 5'b10110, t0b + 134, 66);
      channel_b = 1'b0;
      start_b   = 1'b1;
      n = 0;
      while (cyc < t0b + 134 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      start_b = 1'b0;
      drain(500);
      repeat (100) @(negedge clk);
      chk("continuous final data", 32'(data_b), 32'h155);
      chk("continuous frames", 32'(frames[1]), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
